// File: rtl/parser_rule_ctrl.sv
// Rule configuration front-end for the pipelined packet parser: decodes host
// rule accesses, holds layer-0 extraction registers, forwards the rest downstream.
module parser_rule_ctrl #(
    parameter int unsigned LAYER_NUM         = 4,
    parameter int unsigned TYPE_NUM          = 4,
    parameter int unsigned KEY_FIELD_NUM     = 8,
    parameter int unsigned TYPE_OFFSET_WIDTH = 8,
    parameter int unsigned KEY_OFFSET_WIDTH  = 8,
    parameter int unsigned HEAD_SHIFT_WIDTH  = 8,
    parameter int unsigned META_SHIFT_WIDTH  = 8,
    parameter int unsigned RD_TIMEOUT        = 16
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic                                      i_rule_wren,
    input  logic                                      i_rule_rden,
    input  logic [31:0]                               i_rule_addr,
    input  logic [31:0]                               i_rule_wdata,
    output logic                                      o_rule_rdata_valid,
    output logic [31:0]                               o_rule_rdata,
    output logic                                      o_rule_busy,
    output logic [LAYER_NUM-2:0]                      o_layer_wren,
    output logic [LAYER_NUM-2:0]                      o_layer_rden,
    output logic [31:0]                               o_layer_addr,
    output logic [31:0]                               o_layer_wdata,
    input  logic [LAYER_NUM-2:0]                      i_layer_rdata_valid,
    input  logic [32*(LAYER_NUM-1)-1:0]               i_layer_rdata,
    output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     o_type_offset,
    output logic [KEY_FIELD_NUM-1:0]                  o_key_offset_v,
    output logic [KEY_FIELD_NUM*KEY_OFFSET_WIDTH-1:0] o_key_offset,
    output logic [HEAD_SHIFT_WIDTH-1:0]               o_head_shift,
    output logic [META_SHIFT_WIDTH-1:0]               o_meta_shift
);
    localparam int unsigned NL    = LAYER_NUM - 1;
    localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]             cnt_q;
    logic [NL-1:0]                rd_mask_q;
    logic [TYPE_OFFSET_WIDTH-1:0] type_off_q [TYPE_NUM];
    logic [KEY_OFFSET_WIDTH-1:0]  key_off_q  [KEY_FIELD_NUM];

    logic [7:0]    lid;
    logic [2:0]    itype;
    logic [7:0]    entry;
    logic          wr_acc, rd_acc, lid_local, lid_remote, timeout, sel_valid;
    logic [NL-1:0] lid_onehot;
    logic [31:0]   local_rdata, sel_data;

    assign lid   = i_rule_addr[31:24];
    assign itype = i_rule_addr[18:16];
    assign entry = i_rule_addr[7:0];

    // Write takes priority over a simultaneous read; nothing is accepted in WAIT.
    assign wr_acc     = (state_q == IDLE) && i_rule_wren;
    assign rd_acc     = (state_q == IDLE) && i_rule_rden && !i_rule_wren;
    assign lid_local  = (lid == 8'd0);
    assign lid_remote = !lid_local && (32'(lid) < LAYER_NUM);
    assign timeout    = (cnt_q == CNT_W'(RD_TIMEOUT - 1));
    assign sel_valid  = |(i_layer_rdata_valid & rd_mask_q);
    assign o_rule_busy = (state_q == WAIT);

    always_comb begin
        lid_onehot = '0;
        sel_data   = '0;
        for (int unsigned k = 0; k < NL; k++) begin
            lid_onehot[k] = (32'(lid) == k + 1);
            if (rd_mask_q[k]) sel_data = sel_data | i_layer_rdata[32*k +: 32];
        end
    end

    always_comb begin
        local_rdata = '0;
        case (itype)
            3'd2: for (int unsigned i = 0; i < TYPE_NUM; i++)
                if (32'(entry) == i) local_rdata[TYPE_OFFSET_WIDTH-1:0] = type_off_q[i];
            3'd3: for (int unsigned i = 0; i < KEY_FIELD_NUM; i++)
                if (32'(entry) == i) begin
                    local_rdata[16]                   = o_key_offset_v[i];
                    local_rdata[KEY_OFFSET_WIDTH-1:0] = key_off_q[i];
                end
            3'd4: local_rdata[HEAD_SHIFT_WIDTH-1:0] = o_head_shift;
            3'd5: local_rdata[META_SHIFT_WIDTH-1:0] = o_meta_shift;
            default: ;
        endcase
    end

    always_comb begin
        o_type_offset = '0;
        o_key_offset  = '0;
        for (int unsigned i = 0; i < TYPE_NUM; i++)
            o_type_offset[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH] = type_off_q[i];
        for (int unsigned i = 0; i < KEY_FIELD_NUM; i++)
            o_key_offset[i*KEY_OFFSET_WIDTH +: KEY_OFFSET_WIDTH] = key_off_q[i];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (rd_acc && lid_remote) state_d = WAIT;
            WAIT: if (sel_valid || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            rd_mask_q          <= '0;
            o_rule_rdata_valid <= 1'b0;
            o_rule_rdata       <= '0;
            o_layer_wren       <= '0;
            o_layer_rden       <= '0;
            o_layer_addr       <= '0;
            o_layer_wdata      <= '0;
            o_key_offset_v     <= '0;
            o_head_shift       <= '0;
            o_meta_shift       <= '0;
            for (int unsigned i = 0; i < TYPE_NUM; i++)      type_off_q[i] <= '0;
            for (int unsigned i = 0; i < KEY_FIELD_NUM; i++) key_off_q[i]  <= '0;
        end else begin
            state_q            <= state_d;
            o_layer_wren       <= '0;
            o_layer_rden       <= '0;
            o_rule_rdata_valid <= 1'b0;
            if (wr_acc || rd_acc) begin
                o_layer_addr  <= i_rule_addr;
                o_layer_wdata <= i_rule_wdata;
            end
            if (wr_acc && lid_remote) o_layer_wren <= lid_onehot;
            if (wr_acc && lid_local) begin
                case (itype)
                    3'd2: for (int unsigned i = 0; i < TYPE_NUM; i++)
                        if (32'(entry) == i) type_off_q[i] <= i_rule_wdata[TYPE_OFFSET_WIDTH-1:0];
                    3'd3: for (int unsigned i = 0; i < KEY_FIELD_NUM; i++)
                        if (32'(entry) == i) begin
                            o_key_offset_v[i] <= i_rule_wdata[16];
                            key_off_q[i]      <= i_rule_wdata[KEY_OFFSET_WIDTH-1:0];
                        end
                    3'd4: o_head_shift <= i_rule_wdata[HEAD_SHIFT_WIDTH-1:0];
                    3'd5: o_meta_shift <= i_rule_wdata[META_SHIFT_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (rd_acc) begin
                if (lid_local) begin
                    o_rule_rdata_valid <= 1'b1;
                    o_rule_rdata       <= local_rdata;
                end else if (lid_remote) begin
                    o_layer_rden <= lid_onehot;
                    rd_mask_q    <= lid_onehot;
                    cnt_q        <= '0;
                end else begin
                    o_rule_rdata_valid <= 1'b1;
                    o_rule_rdata       <= '1;
                end
            end
            if (state_q == WAIT) begin
                // A valid in the last timeout cycle still returns real data.
                if (sel_valid) begin
                    o_rule_rdata_valid <= 1'b1;
                    o_rule_rdata       <= sel_data;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout) begin
                        o_rule_rdata_valid <= 1'b1;
                        o_rule_rdata       <= '1;
                    end
                end
            end
        end
    end
endmodule

// File: doc/parser_rule_ctrl.md
Name: parser_rule_ctrl

Overview:
- Configuration front-end for the pipelined packet parser, generalised to LAYER_NUM layers.
- Decodes host rule writes and reads by layer ID and forwards them, registered, to parser layers 1..LAYER_NUM-1.
- Holds the layer-0 extraction registers: type offsets, key offsets, head shift and meta shift.
- Adds full rule read-back: a local 1-cycle path for layer 0, and a handshake with timeout for downstream layers.

Parameters:
LAYER_NUM, 4, number of parser layers including layer 0 (min 2)
TYPE_NUM, 4, layer-0 type-offset entries
KEY_FIELD_NUM, 8, layer-0 key-offset entries
TYPE_OFFSET_WIDTH, 8, bits per type offset
KEY_OFFSET_WIDTH, 8, bits per key offset (max 16)
HEAD_SHIFT_WIDTH, 8, head shift width
META_SHIFT_WIDTH, 8, meta shift width
RD_TIMEOUT, 16, WAIT cycles before a downstream read is abandoned

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_rule_wren  in  1  host write strobe
i_rule_rden  in  1  host read strobe
i_rule_addr  in  32  [31:24] layer ID, [18:16] info type, [7:0] entry ID
i_rule_wdata  in  32  write data
o_rule_rdata_valid  out  1  one-cycle read response strobe
o_rule_rdata  out  32  read response data
o_rule_busy  out  1  downstream read outstanding
o_layer_wren  out  LAYER_NUM-1  per-layer write strobe; bit k-1 targets layer k
o_layer_rden  out  LAYER_NUM-1  per-layer read strobe
o_layer_addr  out  32  registered i_rule_addr
o_layer_wdata  out  32  registered i_rule_wdata
i_layer_rdata_valid  in  LAYER_NUM-1  per-layer read-data strobe
i_layer_rdata  in  32*(LAYER_NUM-1)  per-layer read data, layer k in slice k-1
o_type_offset  out  TYPE_NUM*TYPE_OFFSET_WIDTH  layer-0 type offsets, entry i in slice i
o_key_offset_v  out  KEY_FIELD_NUM  layer-0 key-offset valid bits
o_key_offset  out  KEY_FIELD_NUM*KEY_OFFSET_WIDTH  layer-0 key offsets
o_head_shift  out  HEAD_SHIFT_WIDTH  layer-0 head shift
o_meta_shift  out  META_SHIFT_WIDTH  layer-0 meta shift

Behaviour:

Reset:
- Every output and register is 0; the FSM is in IDLE.
- A reset in WAIT returns the FSM to IDLE with no response. Any later layer valid is ignored.

FSM states:
- IDLE, WAIT.
- o_rule_busy = (state==WAIT), decoded from the state register.

Command acceptance:
- Host commands are sampled only in IDLE. Any wren or rden seen in WAIT is dropped.
- If wren and rden are high together in IDLE, the write is performed and the read is dropped.

Writes (all registered):
- Layer ID k in 1..LAYER_NUM-1: o_layer_wren[k-1]=1 for exactly one cycle after sampling, with o_layer_addr and o_layer_wdata valid in that same cycle.
- Layer ID 0: the local register updates at the sampling edge, so the new value is visible on the outputs in the next cycle.
  - Type 2, entry < TYPE_NUM: type_offset[entry] <= wdata[TYPE_OFFSET_WIDTH-1:0].
  - Type 3, entry < KEY_FIELD_NUM: key_offset_v[entry] <= wdata[16]; key_offset[entry] <= wdata[KEY_OFFSET_WIDTH-1:0].
  - Type 4: head_shift <= wdata[HEAD_SHIFT_WIDTH-1:0].
  - Type 5: meta_shift <= wdata[META_SHIFT_WIDTH-1:0].
  - Any other type, or an out-of-range entry: no effect.
- Layer ID >= LAYER_NUM: dropped silently.

Reads:
- Layer 0: o_rule_rdata_valid=1 in the next cycle. Data is the addressed register zero-extended.
  - Type 3 returns bit16 = valid bit and the low bits = offset.
  - An unmapped type or entry returns 32'h0.
  - The FSM stays in IDLE.
- Layer ID >= LAYER_NUM: 32'hFFFF_FFFF with valid in the next cycle.
- Layer k in 1..LAYER_NUM-1:
  - o_layer_rden[k-1] pulses for one cycle after sampling, with o_layer_addr driven; the FSM enters WAIT and the counter is cleared.
  - In WAIT, i_layer_rdata_valid[k-1]=1 registers i_layer_rdata slice k-1. The response (valid=1) is issued in the next cycle and the FSM returns to IDLE.
  - Valid from any other layer is ignored.
  - The counter increments on each WAIT cycle without a valid. After RD_TIMEOUT such cycles, the response is 32'hFFFF_FFFF in the next cycle and the FSM returns to IDLE.
  - If valid arrives in the final timeout cycle, the valid wins.
- The counter width is clog2(RD_TIMEOUT+1); it does not wrap.
- o_rule_rdata holds its last value between responses.

Test Plan:
- Reset, then write layer0 type3 entry2 wdata=0x0001_0025 -> next cycle o_key_offset_v[2]=1, key_offset[2]=0x25; read back -> rdata=0x0001_0025, 1 cycle after rden.
- Write addr=0x0200_0000, wdata=0xABCD -> o_layer_wren=3'b010, o_layer_wdata=0xABCD for one cycle; layer-0 registers unchanged.
- Read layer 1 with i_layer_rdata_valid[0] returned 3 cycles after o_layer_rden -> o_rule_busy high for those cycles; rdata=layer-1 data one cycle later; busy low.
- Read layer 3 with no valid returned -> after 16 WAIT cycles, rdata=0xFFFF_FFFF with valid; a write issued mid-WAIT has no effect.
- Read layer 2; assert i_rst in the 2nd WAIT cycle, then drive valid -> no o_rule_rdata_valid; busy=0; all layer-0 outputs 0.
- Simultaneous wren+rden to layer0 type4 wdata=0x7 -> head_shift=7; no read response. Read/write of layer ID 5 -> 0xFFFF_FFFF response / no layer strobe.
